// File: rtl/exec_pkg.sv
// Shared execute-stage types and constants: register index, NZCV flags, PC index.
package exec_pkg;

  typedef logic [3:0] reg_idx_t;
  typedef logic [3:0] flags_t;

  localparam reg_idx_t PC_IDX = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmask for RAW hazard detection; registered, one cycle to update.
// Never stalls: a set and a clear on the same index in one cycle leaves the bit set.
module wb_scoreboard
  import exec_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_valid,
  input  reg_idx_t         set_idx,
  input  logic             clr_valid,
  input  reg_idx_t         clr_idx,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_valid) busy_next[clr_idx] = 1'b0;
    // Applied after the clear so a fresh issue survives a same-cycle commit.
    if (set_valid) busy_next[set_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write front end: load-over-ALU arbitration, flag shadow, PC routing.
// Outputs registered at the accepting edge (RF samples next negedge); wb_stall or load blocks ALU.
module reg_writeback #(
  parameter int         NREGS  = 16,
  parameter logic [3:0] PC_IDX = exec_pkg::PC_IDX
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_stall,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [3:0]       ld_rd,
  input  logic [31:0]      ld_data,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [3:0]       alu_rd,
  input  logic [31:0]      alu_result,
  input  logic             alu_write_rd,
  input  logic             alu_set_flags,
  input  logic [3:0]       alu_flags,
  input  logic             issue_valid,
  input  logic [3:0]       issue_rd,
  output logic [NREGS-1:0] busy,
  output logic             rf_not_enable,
  output logic [3:0]       rf_sel_in,
  output logic [31:0]      rf_in_reg,
  output logic [3:0]       rf_in_flags,
  output logic             pc_wr_valid,
  output logic [31:0]      pc_wr_data
);

  import exec_pkg::*;

  flags_t   shadow;
  flags_t   alu_new_flags;
  logic     ld_fire;
  logic     alu_fire;
  logic     alu_to_rf;
  logic     alu_to_pc;
  logic     clr_valid;
  reg_idx_t clr_idx;

  assign ld_ready  = !reset && !wb_stall;
  assign alu_ready = !reset && !wb_stall && !ld_valid;

  assign ld_fire       = ld_valid && ld_ready;
  assign alu_fire      = alu_valid && alu_ready;
  assign alu_to_rf     = alu_write_rd && (alu_rd != PC_IDX);
  assign alu_to_pc     = alu_write_rd && (alu_rd == PC_IDX);
  assign alu_new_flags = alu_set_flags ? alu_flags : shadow;

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_not_enable <= 1'b1;
      rf_sel_in     <= '0;
      rf_in_reg     <= '0;
      rf_in_flags   <= '0;
      shadow        <= '0;
      pc_wr_valid   <= 1'b0;
      pc_wr_data    <= '0;
    end else begin
      rf_not_enable <= 1'b1;
      pc_wr_valid   <= 1'b0;
      if (ld_fire) begin
        if (ld_rd == PC_IDX) begin
          pc_wr_valid <= 1'b1;
          pc_wr_data  <= ld_data;
        end else begin
          rf_not_enable <= 1'b0;
          rf_sel_in     <= ld_rd;
          rf_in_reg     <= ld_data;
          rf_in_flags   <= shadow;
        end
      end else if (alu_fire) begin
        if (alu_to_rf) begin
          rf_not_enable <= 1'b0;
          rf_sel_in     <= alu_rd;
          rf_in_reg     <= alu_result;
          rf_in_flags   <= alu_new_flags;
        end else if (alu_set_flags) begin
          // Flags-only write: index 15 is a dummy the register file does not store.
          rf_not_enable <= 1'b0;
          rf_sel_in     <= PC_IDX;
          rf_in_flags   <= alu_flags;
        end
        if (alu_to_pc) begin
          pc_wr_valid <= 1'b1;
          pc_wr_data  <= alu_result;
        end
        if (alu_set_flags) shadow <= alu_flags;
      end
    end
  end

  assign clr_valid = ld_fire || (alu_fire && alu_write_rd);
  assign clr_idx   = ld_fire ? ld_rd : alu_rd;

  wb_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_valid(issue_valid),
    .set_idx  (issue_rd),
    .clr_valid(clr_valid),
    .clr_idx  (clr_idx),
    .busy     (busy)
  );

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios then random traffic vs a commit-level model.
module tb_reg_writeback;

  logic        clock = 1'b0;
  logic        reset, wb_stall;
  logic        ld_valid, ld_ready, alu_valid, alu_ready;
  logic [3:0]  ld_rd, alu_rd, alu_flags, issue_rd;
  logic [31:0] ld_data, alu_result;
  logic        alu_write_rd, alu_set_flags, issue_valid;
  logic [15:0] busy;
  logic        rf_not_enable, pc_wr_valid;
  logic [3:0]  rf_sel_in, rf_in_flags;
  logic [31:0] rf_in_reg, pc_wr_data;

  int checks = 0;
  int errors = 0;

  // Commit-level reference state
  bit          m_ne;
  bit [3:0]    m_sel, m_flags, m_shadow;
  bit [31:0]   m_reg, m_pcd;
  bit          m_pcv;
  bit [15:0]   m_busy;

  always #5 clock = ~clock;

  reg_writeback dut (
    .clock(clock), .reset(reset), .wb_stall(wb_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .alu_write_rd(alu_write_rd), .alu_set_flags(alu_set_flags), .alu_flags(alu_flags),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .rf_not_enable(rf_not_enable), .rf_sel_in(rf_sel_in), .rf_in_reg(rf_in_reg),
    .rf_in_flags(rf_in_flags), .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One clock of traffic: drive at negedge, check readies, predict, check registered outputs after posedge.
  task automatic step(input bit rst, input bit stall,
                      input bit lv, input bit [3:0] lrd, input bit [31:0] ld,
                      input bit av, input bit [3:0] ard, input bit [31:0] ar,
                      input bit wr, input bit sf, input bit [3:0] af,
                      input bit iv, input bit [3:0] ird);
    bit open, ld_acc, alu_acc;
    @(negedge clock);
    reset = rst; wb_stall = stall;
    ld_valid = lv; ld_rd = lrd; ld_data = ld;
    alu_valid = av; alu_rd = ard; alu_result = ar;
    alu_write_rd = wr; alu_set_flags = sf; alu_flags = af;
    issue_valid = iv; issue_rd = ird;
    #1;
    open    = !rst && !stall;
    ld_acc  = open && lv;
    alu_acc = open && !lv && av;
    check("ld_ready", {31'd0, ld_ready}, {31'd0, open});
    check("alu_ready", {31'd0, alu_ready}, {31'd0, open && !lv});

    m_ne  = 1'b1;
    m_pcv = 1'b0;
    if (rst) begin
      m_sel = 0; m_reg = 0; m_flags = 0; m_shadow = 0; m_pcd = 0; m_busy = 0;
    end else begin
      if (ld_acc) begin
        m_busy[lrd] = 1'b0;
        if (lrd == 4'd15) begin
          m_pcv = 1'b1; m_pcd = ld;
        end else begin
          m_ne = 1'b0; m_sel = lrd; m_reg = ld; m_flags = m_shadow;
        end
      end else if (alu_acc) begin
        if (wr) m_busy[ard] = 1'b0;
        if (wr && ard != 4'd15) begin
          m_ne = 1'b0; m_sel = ard; m_reg = ar; m_flags = sf ? af : m_shadow;
        end else if (sf) begin
          m_ne = 1'b0; m_sel = 4'd15; m_flags = af;
        end
        if (wr && ard == 4'd15) begin
          m_pcv = 1'b1; m_pcd = ar;
        end
        if (sf) m_shadow = af;
      end
      if (iv) m_busy[ird] = 1'b1;
    end

    @(posedge clock);
    #1;
    check("rf_not_enable", {31'd0, rf_not_enable}, {31'd0, m_ne});
    check("rf_sel_in", {28'd0, rf_sel_in}, {28'd0, m_sel});
    check("rf_in_reg", rf_in_reg, m_reg);
    check("rf_in_flags", {28'd0, rf_in_flags}, {28'd0, m_flags});
    check("pc_wr_valid", {31'd0, pc_wr_valid}, {31'd0, m_pcv});
    check("pc_wr_data", pc_wr_data, m_pcd);
    check("busy", {16'd0, busy}, {16'd0, m_busy});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; wb_stall = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    alu_valid = 0; alu_rd = 0; alu_result = 0; alu_write_rd = 0;
    alu_set_flags = 0; alu_flags = 0; issue_valid = 0; issue_rd = 0;

    // Reset, then idle
    step(1, 0, 1, 2, 32'h55, 1, 3, 32'h66, 1, 1, 4'hF, 1, 7);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_ne", {31'd0, rf_not_enable}, 32'd1);
    check("reset_busy", {16'd0, busy}, 32'd0);
    idle();

    // Shadow to 0100, then ALU r3 write without set_flags carries it
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0100, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 32'hAA, 1, 0, 4'b1111, 0, 0);
    check("alu_r3_sel", {28'd0, rf_sel_in}, 32'd3);
    check("alu_r3_flags", {28'd0, rf_in_flags}, 32'b0100);
    idle();
    check("alu_r3_one_cycle", {31'd0, rf_not_enable}, 32'd1);

    // Load beats ALU; ALU follows next cycle
    step(0, 0, 1, 1, 32'h1234, 1, 2, 32'h2222, 1, 0, 0, 0, 0);
    check("ld_first_sel", {28'd0, rf_sel_in}, 32'd1);
    step(0, 0, 0, 0, 0, 1, 2, 32'h2222, 1, 0, 0, 0, 0);
    check("alu_second_data", rf_in_reg, 32'h2222);

    // CMP-style flags-only, then plain ALU write inherits 1000
    step(0, 0, 0, 0, 0, 1, 9, 32'hDEAD, 0, 1, 4'b1000, 0, 0);
    check("cmp_sel", {28'd0, rf_sel_in}, 32'd15);
    step(0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 0, 4'b0001, 0, 0);
    check("r4_flags", {28'd0, rf_in_flags}, 32'b1000);

    // Scoreboard: issue r5, load r5 later; then issue+commit same cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    idle(); idle();
    check("busy5_pending", {31'd0, busy[5]}, 32'd1);
    step(0, 0, 1, 5, 32'h5555, 0, 0, 0, 0, 0, 0, 0, 0);
    check("busy5_cleared", {31'd0, busy[5]}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 1, 5, 32'h5556, 0, 0, 0, 0, 0, 0, 1, 5);
    check("busy5_set_wins", {31'd0, busy[5]}, 32'd1);

    // Load to PC, single pulse; then stall with both valids
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 15);
    step(0, 0, 1, 15, 32'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
    check("pc_pulse", {31'd0, pc_wr_valid}, 32'd1);
    check("pc_busy15", {31'd0, busy[15]}, 32'd0);
    idle();
    check("pc_pulse_once", {31'd0, pc_wr_valid}, 32'd0);
    step(0, 1, 1, 6, 32'h6, 1, 7, 32'h7, 1, 1, 4'h3, 0, 0);
    check("stall_no_write", {31'd0, rf_not_enable}, 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit [3:0] lrd, ard;
      lrd = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      ard = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, lrd, $urandom,
           $urandom_range(0, 1) == 1, ard, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
